pool_stream: RTL and testbench
==============================

# pool_stream

Parametrised streaming K×K pooling stage for the CNN layer chain, successor to the fixed 2×2 max-pooling stage. Accepts a raster stream of UNITS signed channels on the full frame coordinate grid, pools non-overlapping K×K windows (K = 2^POOL_LOG2, stride K) in max or average mode, and emits one result per window at level LEVEL+POOL_LOG2. It sits between a convolution layer's output and the next layer's patch extractor.

## Interface
- WIDTH, -1: active image width in pixels.
- HEIGHT, -1: active image height in pixels.
- W_WIDTH, -1: frame width including blanking.
- W_HEIGHT, -1: frame height including blanking.
- FIXED_BITW, -1: signed width of one channel sample.
- UNITS, -1: number of channels.
- LEVEL, 0: input subsampling level; valid samples have the low LEVEL bits of hcnt and vcnt all ones.
- POOL_LOG2, 1: log2 of window size K; legal values are 1 and 2.
- clock  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_enable  in  1  input sample qualifier.
- in_mode  in  1  0 = max, 1 = average; latched at frame start.
- in_pixels  in  FIXED_BITW*UNITS  channel p at [p*FIXED_BITW +: FIXED_BITW], MSB-first vector.
- in_vcnt  in  log2(W_HEIGHT)  input row coordinate.
- in_hcnt  in  log2(W_WIDTH)  input column coordinate.
- out_enable  out  1  one-cycle pulse per completed window.
- out_pixels  out  FIXED_BITW*UNITS  pooled result; holds between pulses.
- out_vcnt  out  log2(W_HEIGHT)  in_vcnt of the window's closing sample.
- out_hcnt  out  log2(W_WIDTH)  in_hcnt of the window's closing sample.

## Operation
- A sample is valid when all of the following hold: in_enable; hcnt < WIDTH; vcnt < HEIGHT; the low LEVEL bits of hcnt and vcnt are all ones.
- Window phase: hp = hcnt[LEVEL+POOL_LOG2-1:LEVEL], vp = vcnt[same]. Column index = hcnt >> (LEVEL+POOL_LOG2).
- Horizontal accumulator per channel: at hp==0, load the sample; otherwise combine (signed max, or sum).
- At hp==K-1, the row partial is merged into column buffer entry [column index]:
  - vp==0: write.
  - 0<vp<K-1: read-combine-write.
  - vp==K-1: read-combine, then output.
- ACC_BITW = FIXED_BITW + 2*POOL_LOG2.
  - Sums are sign-extended to ACC_BITW.
  - Average = arithmetic shift right by 2*POOL_LOG2 (floor), then truncation to FIXED_BITW. No saturation is needed.
  - Max: strict greater-than; ties keep the earlier value.
- FSM has two states:
  - WAIT_FRAME (reset state): no writes, out_enable held 0. Transitions to RUN on a valid sample with hcnt==LEVEL-ones and vcnt==LEVEL-ones (the frame's first sample). That sample is processed.
  - RUN: stays in RUN until rst.
- in_mode is latched on the frame-start sample. Changes to in_mode mid-frame are ignored.
- Invalid cycles leave all state unchanged. Blanking of any length is legal.
- WIDTH or HEIGHT not divisible by K·2^LEVEL: trailing partial windows are never emitted. Their partials are overwritten in the next frame.

## Timing
- out_enable asserts exactly 2 cycles after the cycle holding the closing sample (hp==K-1, vp==K-1).
  - Stage 1: horizontal result registered; buffer read issued.
  - Stage 2: vertical combine and divide; result registered to the outputs.
- out_pixels, out_vcnt and out_hcnt change only with out_enable.
- Buffer read-modify-write has no hazard: the same entry is revisited at least one input row later.
- Reset values:
  - out_enable = 0, out_pixels = 0, out_vcnt = 0, out_hcnt = 0.
  - Latched mode = max. State = WAIT_FRAME.
- rst mid-frame: in-flight pipeline results are discarded; no output until the next frame start.
- Back-to-back closing samples (K·2^LEVEL apart) give back-to-back pulses at the same spacing.

## Configuration
- POOL_AVG_EN defined: the average datapath is present, and in_mode selects the mode.
- POOL_AVG_EN undefined: max only, in_mode is ignored, and ACC_BITW = FIXED_BITW (smaller buffer).

## Structure
- Package pool_pkg holds:
  - POOL_MAX and POOL_AVG mode constants.
  - FSM state typedef.
  - acc_bitw() and ceil-log2 functions.
- Sub-module pool_line_buf: simple dual-port RAM, depth WIDTH>>(LEVEL+POOL_LOG2), width ACC_BITW*UNITS, one-cycle synchronous read.

## Test plan
- Max, 2×2, LEVEL 0, 8×4 image, UNITS 2, pixel = (v*8+h) on ch0 and the negation on ch1:
  - Expect 8 pulses.
  - First pulse at (1,1): ch0 = 9, ch1 = 0.
- Average (POOL_AVG_EN), 2×2, window {-3,-2,5,7}: output 1 (7/4 floored).
- Window {-1,-1,-1,-2}: output -2.
- POOL_LOG2 = 2, LEVEL = 1, 16×16 image:
  - Pulses only where the low 3 bits of both coordinates are all ones.
  - Latency 2 after the closing sample.
- Random in_enable gaps inside active lines: results identical to the gap-free run.
- rst asserted mid-frame then released: no pulse until the next frame's first window closes; out_* = 0 meanwhile.
- in_mode toggled mid-frame: the whole frame uses the mode latched at frame start; the new mode applies from the next frame.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants, FSM state type and sizing helpers for the streaming pooling stage.
package pool_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } pool_state_t;

    // Ceil-log2 with a floor of one bit so single-entry ports stay legal.
    function automatic int pool_clog2(input int value);
        int r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int acc_bitw(input int fixed_bitw, input int pool_log2, input bit avg_en);
        return avg_en ? fixed_bitw + 2 * pool_log2 : fixed_bitw;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Column buffer holding per-window vertical partials; one write and one registered read per cycle.
module pool_line_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 16
) (
    input  logic          i_clock,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/pool_stream.sv
// Streaming KxK max/average pooling over a raster of UNITS signed channels.
// POOL_AVG_EN enables the average datapath and in_mode; otherwise max-only.
module pool_stream
    import pool_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 4,
    parameter int W_WIDTH    = 10,
    parameter int W_HEIGHT   = 6,
    parameter int FIXED_BITW = 8,
    parameter int UNITS      = 2,
    parameter int LEVEL      = 0,
    parameter int POOL_LOG2  = 1
) (
    input  logic                                 clock,
    input  logic                                 rst,
    input  logic                                 in_enable,
    input  logic                                 in_mode,
    input  logic [FIXED_BITW*UNITS-1:0]          in_pixels,
    input  logic [pool_clog2(W_HEIGHT)-1:0]      in_vcnt,
    input  logic [pool_clog2(W_WIDTH)-1:0]       in_hcnt,
    output logic                                 out_enable,
    output logic [FIXED_BITW*UNITS-1:0]          out_pixels,
    output logic [pool_clog2(W_HEIGHT)-1:0]      out_vcnt,
    output logic [pool_clog2(W_WIDTH)-1:0]       out_hcnt
);

    localparam int HW = pool_clog2(W_WIDTH);
    localparam int VW = pool_clog2(W_HEIGHT);
    localparam int SH = LEVEL + POOL_LOG2;
`ifdef POOL_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif
    localparam int ACC   = acc_bitw(FIXED_BITW, POOL_LOG2, AVG_EN);
    localparam int DEPTH = ((WIDTH >> SH) < 1) ? 1 : (WIDTH >> SH);
    localparam int AW    = pool_clog2(DEPTH);
    localparam logic [HW-1:0] LMASK_H = HW'((1 << LEVEL) - 1);
    localparam logic [VW-1:0] LMASK_V = VW'((1 << LEVEL) - 1);
    localparam logic [HW:0]   WIDTH_C  = (HW + 1)'(WIDTH);
    localparam logic [VW:0]   HEIGHT_C = (VW + 1)'(HEIGHT);

    pool_state_t r_state, w_state_nxt;

    logic                  w_valid, w_first, w_proc, w_close_row, w_last;
    logic [POOL_LOG2-1:0]  w_hp, w_vp;
    logic [AW-1:0]         w_col, w_rd_addr;
    logic signed [ACC-1:0] w_samp [UNITS];
    logic signed [ACC-1:0] w_hcomb [UNITS];
    logic signed [ACC-1:0] w_hnew [UNITS];
    logic signed [ACC-1:0] w_buf [UNITS];
    logic signed [ACC-1:0] w_vmerge [UNITS];
    logic [ACC*UNITS-1:0]  w_rd_data, w_wr_data;
    logic [FIXED_BITW*UNITS-1:0] w_res;

    logic signed [ACC-1:0] r_hacc [UNITS];
    logic signed [ACC-1:0] r_s1_row [UNITS];
    logic                  r_s1_valid;
    logic [POOL_LOG2-1:0]  r_s1_vp;
    logic [AW-1:0]         r_s1_col;
    logic [HW-1:0]         r_s1_hcnt;
    logic [VW-1:0]         r_s1_vcnt;
    logic                  r_out_en;
    logic [FIXED_BITW*UNITS-1:0] r_out_pix;
    logic [VW-1:0]         r_out_vcnt;
    logic [HW-1:0]         r_out_hcnt;

`ifdef POOL_AVG_EN
    logic w_mode, r_mode, r_s1_mode;
    assign w_mode = w_first ? in_mode : r_mode;
`else
    logic w_unused_mode;
    assign w_unused_mode = in_mode;
`endif

    assign w_valid = in_enable && ({1'b0, in_hcnt} < WIDTH_C) && ({1'b0, in_vcnt} < HEIGHT_C)
                     && ((in_hcnt & LMASK_H) == LMASK_H) && ((in_vcnt & LMASK_V) == LMASK_V);
    assign w_first     = w_valid && (in_hcnt == LMASK_H) && (in_vcnt == LMASK_V);
    assign w_proc      = w_valid && (r_state == RUN || w_first);
    assign w_hp        = in_hcnt[LEVEL +: POOL_LOG2];
    assign w_vp        = in_vcnt[LEVEL +: POOL_LOG2];
    assign w_col       = AW'(in_hcnt >> SH);
    assign w_close_row = w_proc && (&w_hp);
    // Address only matters on a row close; parking it at 0 keeps blanking columns in range.
    assign w_rd_addr   = w_close_row ? w_col : '0;
    assign w_last      = r_s1_valid && (&r_s1_vp);

    always_ff @(posedge clock) begin
        if (rst) r_state <= WAIT_FRAME;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_FRAME: if (w_first) w_state_nxt = RUN;
            RUN:        w_state_nxt = RUN;
            default:    w_state_nxt = WAIT_FRAME;
        endcase
    end

    always_comb begin
        w_wr_data = '0;
        w_res     = '0;
        for (int p = 0; p < UNITS; p++) begin
            w_samp[p] = ACC'(signed'(in_pixels[p*FIXED_BITW +: FIXED_BITW]));
            w_buf[p]  = signed'(w_rd_data[p*ACC +: ACC]);
`ifdef POOL_AVG_EN
            w_hcomb[p] = (w_mode == POOL_AVG) ? r_hacc[p] + w_samp[p]
                       : ((w_samp[p] > r_hacc[p]) ? w_samp[p] : r_hacc[p]);
            w_vmerge[p] = (r_s1_vp == '0) ? r_s1_row[p]
                        : (r_s1_mode == POOL_AVG) ? w_buf[p] + r_s1_row[p]
                        : ((r_s1_row[p] > w_buf[p]) ? r_s1_row[p] : w_buf[p]);
            w_res[p*FIXED_BITW +: FIXED_BITW] = (r_s1_mode == POOL_AVG)
                ? FIXED_BITW'(w_vmerge[p] >>> (2 * POOL_LOG2)) : FIXED_BITW'(w_vmerge[p]);
`else
            w_hcomb[p] = (w_samp[p] > r_hacc[p]) ? w_samp[p] : r_hacc[p];
            w_vmerge[p] = (r_s1_vp == '0) ? r_s1_row[p]
                        : ((r_s1_row[p] > w_buf[p]) ? r_s1_row[p] : w_buf[p]);
            w_res[p*FIXED_BITW +: FIXED_BITW] = FIXED_BITW'(w_vmerge[p]);
`endif
            w_hnew[p] = (w_hp == '0) ? w_samp[p] : w_hcomb[p];
            w_wr_data[p*ACC +: ACC] = w_vmerge[p];
        end
    end

    always_ff @(posedge clock) begin
        if (w_proc) r_hacc <= w_hnew;
        if (w_close_row) begin
            r_s1_row  <= w_hnew;
            r_s1_vp   <= w_vp;
            r_s1_col  <= w_col;
            r_s1_hcnt <= in_hcnt;
            r_s1_vcnt <= in_vcnt;
`ifdef POOL_AVG_EN
            r_s1_mode <= w_mode;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_out_en   <= 1'b0;
            r_out_pix  <= '0;
            r_out_vcnt <= '0;
            r_out_hcnt <= '0;
`ifdef POOL_AVG_EN
            r_mode     <= POOL_MAX;
`endif
        end else begin
            r_s1_valid <= w_close_row;
            r_out_en   <= w_last;
            if (w_last) begin
                r_out_pix  <= w_res;
                r_out_vcnt <= r_s1_vcnt;
                r_out_hcnt <= r_s1_hcnt;
            end
`ifdef POOL_AVG_EN
            if (w_first) r_mode <= in_mode;
`endif
        end
    end

    // The final row of a window only reads; its merged value goes straight to the outputs.
    pool_line_buf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (ACC * UNITS)
    ) u_line_buf (
        .i_clock   (clock),
        .i_wr_en   (r_s1_valid && !(&r_s1_vp)),
        .i_wr_addr (r_s1_col),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign out_enable = r_out_en;
    assign out_pixels = r_out_pix;
    assign out_vcnt   = r_out_vcnt;
    assign out_hcnt   = r_out_hcnt;

endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream: 2x2 two-channel instance (A) and 8x8-at-level-1 instance (B).
module tb_pool_stream;

`ifdef POOL_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic        a_en, a_mode, a_oen;
    logic [15:0] a_pix, a_opix;
    logic [2:0]  a_v, a_ov;
    logic [3:0]  a_h, a_oh;
    logic        b_en, b_mode, b_oen;
    logic [7:0]  b_pix, b_opix;
    logic [4:0]  b_v, b_h, b_ov, b_oh;

    pool_stream #(.WIDTH(8), .HEIGHT(4), .W_WIDTH(10), .W_HEIGHT(6), .FIXED_BITW(8),
                  .UNITS(2), .LEVEL(0), .POOL_LOG2(1)) u_dut_a (
        .clock(clk), .rst(rst), .in_enable(a_en), .in_mode(a_mode), .in_pixels(a_pix),
        .in_vcnt(a_v), .in_hcnt(a_h), .out_enable(a_oen), .out_pixels(a_opix),
        .out_vcnt(a_ov), .out_hcnt(a_oh));

    pool_stream #(.WIDTH(16), .HEIGHT(16), .W_WIDTH(18), .W_HEIGHT(18), .FIXED_BITW(8),
                  .UNITS(1), .LEVEL(1), .POOL_LOG2(2)) u_dut_b (
        .clock(clk), .rst(rst), .in_enable(b_en), .in_mode(b_mode), .in_pixels(b_pix),
        .in_vcnt(b_v), .in_hcnt(b_h), .out_enable(b_oen), .out_pixels(b_opix),
        .out_vcnt(b_ov), .out_hcnt(b_oh));

    typedef struct {
        int          v;
        int          h;
        logic [15:0] pix;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0, failures = 0, cyc = 0, a_pulses = 0;
    int   pa [0:5][0:9][0:1];
    int   pb [0:17][0:17];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_a(input int v, input int h, input int ch, input bit avg);
        int mx = -100000, sum = 0;
        for (int vv = (v & ~1); vv < (v & ~1) + 2; vv++)
            for (int hh = (h & ~1); hh < (h & ~1) + 2; hh++) begin
                sum += pa[vv][hh][ch];
                if (pa[vv][hh][ch] > mx) mx = pa[vv][hh][ch];
            end
        return avg ? (sum >>> 2) : mx;
    endfunction

    function automatic int model_b(input int v, input int h);
        int mx = -100000;
        for (int vv = (v & ~7); vv < (v & ~7) + 8; vv++)
            for (int hh = (h & ~7); hh < (h & ~7) + 8; hh++)
                if ((vv & 1) && (hh & 1) && pb[vv][hh] > mx) mx = pb[vv][hh];
        return mx;
    endfunction

    always @(negedge clk) begin
        if (a_oen) begin
            a_pulses++;
            checks++;
            if (qa.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_pulse got v=%0d h=%0d pix=%h, no pulse required", a_ov, a_oh, a_opix);
            end else begin
                ea = qa.pop_front();
                if (a_opix !== ea.pix || a_ov !== 3'(ea.v) || a_oh !== 4'(ea.h) || cyc != ea.due) begin
                    failures++;
                    $display("FAIL a_pulse got v=%0d h=%0d pix=%h cyc=%0d, want v=%0d h=%0d pix=%h cyc=%0d",
                             a_ov, a_oh, a_opix, cyc, ea.v, ea.h, ea.pix, ea.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_oen) begin
            checks++;
            if (qb.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_pulse got v=%0d h=%0d pix=%h, no pulse required", b_ov, b_oh, b_opix);
            end else begin
                eb = qb.pop_front();
                if (b_opix !== eb.pix[7:0] || b_ov !== 5'(eb.v) || b_oh !== 5'(eb.h) || cyc != eb.due) begin
                    failures++;
                    $display("FAIL b_pulse got v=%0d h=%0d pix=%h cyc=%0d, want v=%0d h=%0d pix=%h cyc=%0d",
                             b_ov, b_oh, b_opix, cyc, eb.v, eb.h, eb.pix[7:0], eb.due);
                end
            end
        end
    end

    task automatic check_idle(input string name);
        checks++;
        if (a_oen !== 1'b0 || a_opix !== 16'h0 || a_ov !== 3'h0 || a_oh !== 4'h0 ||
            b_oen !== 1'b0 || b_opix !== 8'h0 || b_ov !== 5'h0 || b_oh !== 5'h0) begin
            failures++;
            $display("FAIL %s got a_en=%b a_pix=%h a_v=%0d a_h=%0d b_en=%b b_pix=%h, want all zero",
                     name, a_oen, a_opix, a_ov, a_oh, b_oen, b_opix);
        end
    endtask

    task automatic fill_ramp();
        for (int v = 0; v < 6; v++)
            for (int h = 0; h < 10; h++) begin
                pa[v][h][0] = (v < 4 && h < 8) ? v * 8 + h : 127;
                pa[v][h][1] = (v < 4 && h < 8) ? -(v * 8 + h) : -128;
            end
    endtask

    task automatic fill_directed();
        for (int v = 0; v < 6; v++)
            for (int h = 0; h < 10; h++) begin
                pa[v][h][0] = (v < 4 && h < 8) ? 0 : 127;
                pa[v][h][1] = (v < 4 && h < 8) ? 0 : 127;
            end
        pa[0][0][0] = -3; pa[0][1][0] = -2; pa[1][0][0] = 5;  pa[1][1][0] = 7;
        pa[0][0][1] = -1; pa[0][1][1] = -1; pa[1][0][1] = -1; pa[1][1][1] = -2;
        pa[2][6][0] = -7; pa[2][7][0] = -8; pa[3][6][0] = -8; pa[3][7][0] = -9;
    endtask

    task automatic a_frame(input bit mode_first, input bit mode_rest, input bit gaps,
                           input int rst_v, input int rst_h);
        bit   dead = 1'b0;
        exp_t e;
        for (int v = 0; v < 6; v++)
            for (int h = 0; h < 10; h++) begin
                if (gaps && v < 4 && h < 8)
                    repeat ($urandom_range(0, 2)) begin
                        a_en = 1'b0; a_mode = ~mode_first;
                        a_v = 3'($urandom_range(0, 7)); a_h = 4'($urandom_range(0, 15));
                        a_pix = 16'($urandom);
                        @(posedge clk); #1;
                    end
                a_en   = 1'b1;
                a_v    = 3'(v);
                a_h    = 4'(h);
                a_mode = (v == 0 && h == 0) ? mode_first : mode_rest;
                a_pix  = {8'(pa[v][h][1]), 8'(pa[v][h][0])};
                if (!dead && v < 4 && h < 8 && (v % 2) == 1 && (h % 2) == 1 &&
                    !(v == rst_v && h == rst_h)) begin
                    e.v = v; e.h = h; e.due = cyc + 2;
                    e.pix = {8'(model_a(v, h, 1, AVG_EN && mode_first)),
                             8'(model_a(v, h, 0, AVG_EN && mode_first))};
                    qa.push_back(e);
                end
                @(posedge clk); #1;
                if (v == rst_v && h == rst_h) begin
                    rst = 1'b1; a_en = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b0; dead = 1'b1;
                    check_idle("mid_frame_reset_outputs");
                end
            end
        a_en = 1'b0;
    endtask

    task automatic b_frame();
        exp_t e;
        for (int v = 0; v < 18; v++)
            for (int h = 0; h < 18; h++)
                pb[v][h] = (v < 16 && h < 16 && (v & 1) && (h & 1)) ? (v >> 1) * 8 + (h >> 1) : 127;
        for (int v = 0; v < 18; v++)
            for (int h = 0; h < 18; h++) begin
                b_en = 1'b1; b_v = 5'(v); b_h = 5'(h); b_pix = 8'(pb[v][h]);
                if (v < 16 && h < 16 && (v & 7) == 7 && (h & 7) == 7) begin
                    e.v = v; e.h = h; e.due = cyc + 2;
                    e.pix = {8'h00, 8'(model_b(v, h))};
                    qb.push_back(e);
                end
                @(posedge clk); #1;
            end
        b_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_en = 1'b0; a_mode = 1'b0; a_pix = '0; a_v = '0; a_h = '0;
        b_en = 1'b0; b_mode = 1'b0; b_pix = '0; b_v = '0; b_h = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_outputs");
        rst = 1'b0;
        @(posedge clk); #1;

        fill_ramp();
        a_frame(1'b0, 1'b0, 1'b0, -1, -1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_pulses != 8) begin
            failures++;
            $display("FAIL a_pulse_count got %0d want 8", a_pulses);
        end

        a_frame(1'b0, 1'b0, 1'b1, -1, -1);
        a_frame(1'b1, 1'b0, 1'b0, -1, -1);
        a_frame(1'b0, 1'b1, 1'b1, -1, -1);
        fill_directed();
        a_frame(1'b1, 1'b1, 1'b0, -1, -1);
        fill_ramp();
        a_frame(1'b0, 1'b0, 1'b0, 1, 5);
        a_frame(1'b0, 1'b0, 1'b0, -1, -1);

        b_frame();
        repeat (5) @(posedge clk);
        #1;

        checks++;
        if (qa.size() != 0) begin
            failures++;
            $display("FAIL a_missing_pulses got %0d outstanding want 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            failures++;
            $display("FAIL b_missing_pulses got %0d outstanding want 0", qb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
